// File: rtl/wb_regfile_if.sv
// Writeback-to-register-file bus: W-stage write request, D-stage read ports, commit trace.
interface wb_regfile_if #(
  parameter int unsigned DATA_W = 32
);
  logic              we;
  logic [4:0]        wa;
  logic [DATA_W-1:0] wd;
  logic [31:0]       wpc;
  logic [4:0]        ra1;
  logic [4:0]        ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              commit_valid;
  logic [31:0]       commit_pc;
  logic [4:0]        commit_reg;
  logic [DATA_W-1:0] commit_data;
  logic [31:0]       wcount;

  modport master (
    output we, wa, wd, wpc, ra1, ra2,
    input  rd1, rd2, commit_valid, commit_pc, commit_reg, commit_data, wcount
  );

  modport slave (
    input  we, wa, wd, wpc, ra1, ra2,
    output rd1, rd2, commit_valid, commit_pc, commit_reg, commit_data, wcount
  );
endinterface

// File: rtl/wb_regfile.sv
// General register file on the writeback side: one write port, two bypassing read ports,
// plus a registered commit record and accepted-write counter for trace checking.
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter bit          BYPASS = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  wb_regfile_if.slave    bus
);

  localparam int unsigned NREGS = 32;
  localparam int unsigned CNT_W = 32;

  logic [DATA_W-1:0] regs [NREGS];
  logic [CNT_W-1:0]  wcount_q;
  logic              accept;

  // Writes to r0 are dropped entirely: no storage, no commit, no count.
  assign accept     = bus.we && (bus.wa != 5'd0);
  assign bus.wcount = wcount_q;

  // Read port 1: r0 reads zero, then same-cycle bypass, then storage.
  always_comb begin
    bus.rd1 = regs[bus.ra1];
    if (bus.ra1 == 5'd0) begin
      bus.rd1 = '0;
    end else if (BYPASS && bus.we && (bus.wa == bus.ra1)) begin
      bus.rd1 = bus.wd;
    end
  end

  // Read port 2: identical selection to port 1.
  always_comb begin
    bus.rd2 = regs[bus.ra2];
    if (bus.ra2 == 5'd0) begin
      bus.rd2 = '0;
    end else if (BYPASS && bus.we && (bus.wa == bus.ra2)) begin
      bus.rd2 = bus.wd;
    end
  end

  // Storage, commit record and counter; reset wins over a coincident write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[5'(i)] <= '0;
      end
      bus.commit_valid <= 1'b0;
      bus.commit_pc    <= '0;
      bus.commit_reg   <= '0;
      bus.commit_data  <= '0;
      wcount_q         <= '0;
    end else begin
      bus.commit_valid <= accept;
      if (accept) begin
        regs[bus.wa]    <= bus.wd;
        bus.commit_pc   <= bus.wpc;
        bus.commit_reg  <= bus.wa;
        bus.commit_data <= bus.wd;
      end
      // Counter is rewritten every cycle so it wraps naturally at 2^32.
      wcount_q <= wcount_q + CNT_W'(accept);
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; two instances cover BYPASS=1 and BYPASS=0.
module tb_wb_regfile;

  localparam int unsigned DW = 32;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  wb_regfile_if #(.DATA_W(DW)) wif1 ();
  wb_regfile_if #(.DATA_W(DW)) wif0 ();

  wb_regfile #(.DATA_W(DW), .BYPASS(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(wif1));
  wb_regfile #(.DATA_W(DW), .BYPASS(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(wif0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Both instances always see identical stimulus.
  task automatic drive(input logic we, input logic [4:0] wa, input logic [DW-1:0] wd,
                       input logic [31:0] wpc, input logic [4:0] ra1, input logic [4:0] ra2);
    wif1.we = we;  wif1.wa = wa;  wif1.wd = wd;  wif1.wpc = wpc;  wif1.ra1 = ra1;  wif1.ra2 = ra2;
    wif0.we = we;  wif0.wa = wa;  wif0.wd = wd;  wif0.wpc = wpc;  wif0.ra1 = ra1;  wif0.ra2 = ra2;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(1'b0, 5'd0, '0, 32'h0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 5'd0, '0, 32'h0, 5'd5, 5'd31);
    #1;
    checks++; if (wif1.rd1 !== 32'h0) begin errors++; $display("FAIL reset_rd1 got %h exp %h", wif1.rd1, 32'h0); end
    checks++; if (wif1.rd2 !== 32'h0) begin errors++; $display("FAIL reset_rd2 got %h exp %h", wif1.rd2, 32'h0); end
    checks++; if (wif1.wcount !== 32'h0) begin errors++; $display("FAIL reset_wcount got %h exp %h", wif1.wcount, 32'h0); end
    checks++; if (wif1.commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit_valid got %b exp 0", wif1.commit_valid); end
    checks++; if (wif1.commit_pc !== 32'h0) begin errors++; $display("FAIL reset_commit_pc got %h exp %h", wif1.commit_pc, 32'h0); end
  endtask

  task automatic test_write;
    @(negedge clk);
    drive(1'b1, 5'd8, 32'h1234_5678, 32'h0000_3010, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, '0, 32'h0, 5'd8, 5'd0);
    #1;
    checks++; if (wif1.commit_valid !== 1'b1) begin errors++; $display("FAIL write_commit_valid got %b exp 1", wif1.commit_valid); end
    checks++; if (wif1.commit_pc !== 32'h0000_3010) begin errors++; $display("FAIL write_commit_pc got %h exp %h", wif1.commit_pc, 32'h0000_3010); end
    checks++; if (wif1.commit_reg !== 5'd8) begin errors++; $display("FAIL write_commit_reg got %0d exp 8", wif1.commit_reg); end
    checks++; if (wif1.commit_data !== 32'h1234_5678) begin errors++; $display("FAIL write_commit_data got %h exp %h", wif1.commit_data, 32'h1234_5678); end
    checks++; if (wif1.wcount !== 32'd1) begin errors++; $display("FAIL write_wcount got %0d exp 1", wif1.wcount); end
    checks++; if (wif1.rd1 !== 32'h1234_5678) begin errors++; $display("FAIL write_rd1 got %h exp %h", wif1.rd1, 32'h1234_5678); end
    @(negedge clk);
    #1;
    checks++; if (wif1.commit_valid !== 1'b0) begin errors++; $display("FAIL write_commit_drop got %b exp 0", wif1.commit_valid); end
    checks++; if (wif1.commit_data !== 32'h1234_5678) begin errors++; $display("FAIL write_commit_hold got %h exp %h", wif1.commit_data, 32'h1234_5678); end
  endtask

  task automatic test_reject_r0;
    @(negedge clk);
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0000_3014, 5'd0, 5'd0);
    #1;
    checks++; if (wif1.rd1 !== 32'h0) begin errors++; $display("FAIL r0_bypass_rd1 got %h exp %h", wif1.rd1, 32'h0); end
    @(negedge clk);
    drive(1'b0, 5'd0, '0, 32'h0, 5'd0, 5'd0);
    #1;
    checks++; if (wif1.commit_valid !== 1'b0) begin errors++; $display("FAIL r0_commit_valid got %b exp 0", wif1.commit_valid); end
    checks++; if (wif1.wcount !== 32'd1) begin errors++; $display("FAIL r0_wcount got %0d exp 1", wif1.wcount); end
    checks++; if (wif1.rd1 !== 32'h0) begin errors++; $display("FAIL r0_read got %h exp %h", wif1.rd1, 32'h0); end
  endtask

  task automatic test_bypass;
    @(negedge clk);
    drive(1'b1, 5'd9, 32'h1, 32'h0000_3020, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b1, 5'd9, 32'hAB, 32'h0000_3024, 5'd9, 5'd9);
    #1;
    checks++; if (wif1.rd1 !== 32'hAB) begin errors++; $display("FAIL bypass1_rd1 got %h exp %h", wif1.rd1, 32'hAB); end
    checks++; if (wif1.rd2 !== 32'hAB) begin errors++; $display("FAIL bypass1_rd2 got %h exp %h", wif1.rd2, 32'hAB); end
    checks++; if (wif0.rd1 !== 32'h1) begin errors++; $display("FAIL bypass0_rd1_pre got %h exp %h", wif0.rd1, 32'h1); end
    checks++; if (wif0.rd2 !== 32'h1) begin errors++; $display("FAIL bypass0_rd2_pre got %h exp %h", wif0.rd2, 32'h1); end
    @(negedge clk);
    // we=0 with live-looking wa/wd must not bypass.
    drive(1'b0, 5'd9, 32'hDEAD_BEEF, 32'h0, 5'd9, 5'd9);
    #1;
    checks++; if (wif0.rd1 !== 32'hAB) begin errors++; $display("FAIL bypass0_rd1_post got %h exp %h", wif0.rd1, 32'hAB); end
    checks++; if (wif0.rd2 !== 32'hAB) begin errors++; $display("FAIL bypass0_rd2_post got %h exp %h", wif0.rd2, 32'hAB); end
    checks++; if (wif1.rd1 !== 32'hAB) begin errors++; $display("FAIL bypass1_no_we got %h exp %h", wif1.rd1, 32'hAB); end
    checks++; if (wif1.wcount !== 32'd3) begin errors++; $display("FAIL bypass_wcount got %0d exp 3", wif1.wcount); end
  endtask

  task automatic test_back_to_back;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      drive(1'b1, 5'd3, DW'(i), 32'h0000_3100 + 32'(4 * i), 5'd0, 5'd0);
      #1;
      if (i > 1) begin
        checks++; if (wif1.commit_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_%0d got %b exp 1", i - 1, wif1.commit_valid); end
        checks++; if (wif1.commit_data !== DW'(i - 1)) begin errors++; $display("FAIL b2b_data_%0d got %h exp %h", i - 1, wif1.commit_data, DW'(i - 1)); end
        checks++; if (wif1.wcount !== 32'(3 + i - 1)) begin errors++; $display("FAIL b2b_wcount_%0d got %0d exp %0d", i - 1, wif1.wcount, 3 + i - 1); end
      end
    end
    @(negedge clk);
    drive(1'b0, 5'd0, '0, 32'h0, 5'd3, 5'd8);
    #1;
    checks++; if (wif1.commit_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_3 got %b exp 1", wif1.commit_valid); end
    checks++; if (wif1.commit_data !== 32'd3) begin errors++; $display("FAIL b2b_data_3 got %h exp %h", wif1.commit_data, 32'd3); end
    checks++; if (wif1.commit_reg !== 5'd3) begin errors++; $display("FAIL b2b_reg got %0d exp 3", wif1.commit_reg); end
    checks++; if (wif1.commit_pc !== 32'h0000_310C) begin errors++; $display("FAIL b2b_pc got %h exp %h", wif1.commit_pc, 32'h0000_310C); end
    checks++; if (wif1.wcount !== 32'd6) begin errors++; $display("FAIL b2b_wcount got %0d exp 6", wif1.wcount); end
    checks++; if (wif1.rd1 !== 32'd3) begin errors++; $display("FAIL b2b_reg3 got %h exp %h", wif1.rd1, 32'd3); end
    checks++; if (wif1.rd2 !== 32'h1234_5678) begin errors++; $display("FAIL b2b_reg8 got %h exp %h", wif1.rd2, 32'h1234_5678); end
  endtask

  task automatic test_reset_priority;
    @(negedge clk);
    drive(1'b1, 5'd4, 32'h55, 32'h0000_3200, 5'd0, 5'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 5'd4, 32'h66, 32'h0000_3204, 5'd4, 5'd3);
    #1;
    checks++; if (wif1.rd1 !== 32'h66) begin errors++; $display("FAIL rst_cycle_rd1 got %h exp %h", wif1.rd1, 32'h66); end
    checks++; if (wif0.rd1 !== 32'h55) begin errors++; $display("FAIL rst_cycle_rd1_nobyp got %h exp %h", wif0.rd1, 32'h55); end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 5'd0, '0, 32'h0, 5'd4, 5'd3);
    #1;
    checks++; if (wif1.rd1 !== 32'h0) begin errors++; $display("FAIL rst_prio_rd1 got %h exp %h", wif1.rd1, 32'h0); end
    checks++; if (wif1.rd2 !== 32'h0) begin errors++; $display("FAIL rst_prio_rd2 got %h exp %h", wif1.rd2, 32'h0); end
    checks++; if (wif1.wcount !== 32'h0) begin errors++; $display("FAIL rst_prio_wcount got %0d exp 0", wif1.wcount); end
    checks++; if (wif1.commit_valid !== 1'b0) begin errors++; $display("FAIL rst_prio_valid got %b exp 0", wif1.commit_valid); end
    checks++; if (wif1.commit_data !== 32'h0) begin errors++; $display("FAIL rst_prio_data got %h exp %h", wif1.commit_data, 32'h0); end
    checks++; if (wif1.commit_reg !== 5'd0) begin errors++; $display("FAIL rst_prio_reg got %0d exp 0", wif1.commit_reg); end
  endtask

  task automatic test_wrap;
    // Preload the counter near its limit; an idle edge copies the value into the register.
    force dut1.wcount_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut1.wcount_q;
    #1;
    checks++; if (wif1.wcount !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload got %h exp %h", wif1.wcount, 32'hFFFF_FFFF); end
    drive(1'b1, 5'd5, 32'h7, 32'h0000_3300, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, '0, 32'h0, 5'd5, 5'd0);
    #1;
    checks++; if (wif1.wcount !== 32'h0) begin errors++; $display("FAIL wrap_wcount got %h exp %h", wif1.wcount, 32'h0); end
    checks++; if (wif1.commit_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got %b exp 1", wif1.commit_valid); end
    checks++; if (wif1.rd1 !== 32'h7) begin errors++; $display("FAIL wrap_rd1 got %h exp %h", wif1.rd1, 32'h7); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(1'b0, 5'd0, '0, 32'h0, 5'd0, 5'd0);
    test_reset();
    test_write();
    test_reject_r0();
    test_bypass();
    test_back_to_back();
    test_reset_priority();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
